aib_txfifo_rd_ctrl: RTL

//  Read-side controller of the AIB TX phase-compensation FIFO. Syncs the write-domain Gray entry

---
 rtl/aib_txfifo_pkg.sv | 29 ++
 rtl/aib_txfifo_ptr_sync.sv | 44 ++++
 rtl/aib_txfifo_rd_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/aib_txfifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aib_txfifo_pkg                                                           |
// | Shared types and helpers for the AIB TX FIFO read-side controller.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package aib_txfifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        UFLOW = 2'd3
    } rd_state_e;

    localparam int UFLOW_CNT_W = 8;

    // Callers zero-extend narrower pointers; leading zeros decode to zeros.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aib_txfifo_ptr_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aib_txfifo_ptr_sync                                                      |
// | Multi-stage synchronizer for the Gray write pointer, binary output.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module aib_txfifo_ptr_sync
    import aib_txfifo_pkg::*;
#(
    parameter int PTRW        = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PTRW-1:0] wr_ptr_gray,
    output logic [PTRW-1:0] wr_ptr_bin
);

    logic [PTRW-1:0] sync_q [SYNC_STAGES];
    logic [PTRW-1:0] sync_d [SYNC_STAGES];

    always_comb begin
        sync_d[0] = wr_ptr_gray;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign wr_ptr_bin = PTRW'(gray2bin(32'(sync_q[SYNC_STAGES-1])));

endmodule
`default_nettype wire

// File: rtl/aib_txfifo_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aib_txfifo_rd_ctrl                                                       |
// | Read-side controller of the AIB TX phase-compensation FIFO: fill level,  |
// | read FSM and one-hot word selector. Optional AIB_TXFIFO_UFLOW_CNT_EN     |
// | adds a saturating underflow event counter.                               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module aib_txfifo_rd_ctrl
    import aib_txfifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int DEPTH4       = DEPTH * 4,
    parameter int PTRW         = $clog2(DEPTH) + 1,
    parameter int RD_START_LVL = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic              rd_start,
    input  logic [PTRW-1:0]   wr_ptr_gray,
    output logic [DEPTH4-1:0] fifo_rd_en,
    output logic              rd_valid,
    output logic [PTRW-1:0]   fill_level,
    output logic [1:0]        rd_state,
    output logic              underflow
`ifdef AIB_TXFIFO_UFLOW_CNT_EN
    ,
    output logic [UFLOW_CNT_W-1:0] uflow_cnt
`endif
);

    localparam int              WPTRW     = PTRW + 2;
    localparam int              SLOTW     = PTRW + 1;
    localparam logic [PTRW-1:0] START_LVL = PTRW'(RD_START_LVL);

    rd_state_e         state_q, state_d;
    logic [WPTRW-1:0]  rd_wptr_q, rd_wptr_d;
    logic [DEPTH4-1:0] fifo_rd_en_q, fifo_rd_en_d;
    logic              rd_valid_q, rd_valid_d;
    logic [PTRW-1:0]   wr_ptr_bin;
    logic [SLOTW-1:0]  slot;
    logic              issue;

    aib_txfifo_ptr_sync #(
        .PTRW        (PTRW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ptr_sync (
        .clk         (rd_clk),
        .rst_n       (rd_rst_n),
        .wr_ptr_gray (wr_ptr_gray),
        .wr_ptr_bin  (wr_ptr_bin)
    );

    // Word pointer: low two bits pick the word within an entry, the rest is the entry pointer.
    assign slot       = rd_wptr_q[SLOTW-1:0];
    assign fill_level = wr_ptr_bin - rd_wptr_q[WPTRW-1:2];

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_start) state_d = FILL;
            FILL:    if (!rd_start) state_d = IDLE;
                     else if (fill_level >= START_LVL) state_d = RUN;
            RUN:     if (!rd_start) state_d = IDLE;
                     else if (fill_level == '0) state_d = UFLOW;
            UFLOW:   if (!rd_start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue        = (state_q == RUN) && rd_start && (fill_level != '0);
        rd_wptr_d    = issue ? rd_wptr_q + WPTRW'(1) : rd_wptr_q;
        fifo_rd_en_d = issue ? (DEPTH4'(1) << slot) : '0;
        rd_valid_d   = |fifo_rd_en_q;
        underflow    = (state_q == UFLOW);
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_wptr_q    <= '0;
            fifo_rd_en_q <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            rd_wptr_q    <= rd_wptr_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign fifo_rd_en = fifo_rd_en_q;
    assign rd_valid   = rd_valid_q;
    assign rd_state   = state_q;

`ifdef AIB_TXFIFO_UFLOW_CNT_EN
    logic [UFLOW_CNT_W-1:0] uflow_cnt_q, uflow_cnt_d;

    always_comb begin
        uflow_cnt_d = uflow_cnt_q;
        if ((state_q == RUN) && (state_d == UFLOW) && (uflow_cnt_q != '1)) begin
            uflow_cnt_d = uflow_cnt_q + UFLOW_CNT_W'(1);
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            uflow_cnt_q <= '0;
        end else begin
            uflow_cnt_q <= uflow_cnt_d;
        end
    end

    assign uflow_cnt = uflow_cnt_q;
`endif

endmodule
`default_nettype wire
